hilo_acc: RTL and testbench
===========================

HILO_ACC -- requirements
Module: hilo_acc

Interface
REQ-001 Parameter: HW, 32, width of each half (HI and LO); the register pair is 2*HW bits.
REQ-002 Parameter: RST_VAL, 0, reset value of the 2*HW register pair.
REQ-003 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-high reset.
REQ-005 Port: req  in  1  operation request; sampled only when ready=1.
REQ-006 Port: op  in  3  opcode: 0 NOP, 1 MTHI, 2 MTLO, 3 WBOTH, 4 MADD, 5 MSUB; codes 6 and 7 are treated as NOP.
REQ-007 Port: wdata  in  2*HW  operand; HI half is [2HW-1:HW], LO half is [HW-1:0].
REQ-008 Port: ready  out  1  high when a request can be accepted.
REQ-009 Port: done  out  1  one-cycle pulse when an accepted operation has fully committed.
REQ-010 Port: rdata  out  2*HW  current {HI,LO} value, with forwarding per REQ-031.

Function
REQ-011 The block SHALL hold two state-machine states, IDLE and ACC_HI.
REQ-012 ready SHALL be 1 exactly when the state is IDLE.
REQ-013 A request SHALL be accepted when req=1, ready=1 and op is 1 to 5; all other cycles SHALL leave HI, LO and the state unchanged.
REQ-014 On an accepted MTHI, HI SHALL be loaded with wdata HI half on that edge; LO is unchanged; done=1 in the following cycle.
REQ-015 On an accepted MTLO, LO SHALL be loaded with wdata LO half on that edge; HI is unchanged; done=1 in the following cycle.
REQ-016 On an accepted WBOTH, {HI,LO} SHALL be loaded with wdata on that edge; done=1 in the following cycle.
REQ-017 Accepted MADD/MSUB, edge 1: LO <= LO +/- wdata LO half, modulo 2^HW.
REQ-018 At the same edge, the carry (MADD) or borrow (MSUB) out of bit HW-1, the wdata HI half and the operation kind SHALL be registered, and the state SHALL move to ACC_HI.
REQ-019 In ACC_HI, edge 2: HI <= HI + opHI + carry (MADD) or HI - opHI - borrow (MSUB), modulo 2^HW; the state SHALL return to IDLE.
REQ-020 done SHALL be 1 in the cycle after edge 2, so the total latency is 2 cycles and the result equals {HI,LO} +/- wdata modulo 2^(2HW), signedness-agnostic.
REQ-021 During ACC_HI, req SHALL be ignored (ready=0); the requester holds its request until ready returns to 1.
REQ-022 Back-to-back plain writes SHALL be accepted every cycle; a MADD/MSUB immediately after ACC_HI SHALL see the fully committed HI.
REQ-023 done SHALL be a registered signal, 0 in every cycle not listed in REQ-014 to REQ-016 and REQ-020.
REQ-031 rdata SHALL be the registered {HI,LO}, except as modified by HILO_BYPASS_EN (REQ-041).
REQ-032 In ACC_HI, rdata SHALL expose the updated LO with the old HI; consumers SHALL rely on the value only when ready=1.

Reset
REQ-033 While rst=1, {HI,LO}=RST_VAL, state=IDLE, done=0, ready=1, and the registered carry and operand are 0.
REQ-034 rst asserted during ACC_HI SHALL abort the accumulate without completing HI and without a done pulse.

Configuration
REQ-040 Macro HILO_BYPASS_EN SHALL select same-cycle write forwarding.
REQ-041 With HILO_BYPASS_EN defined, rdata SHALL combinationally reflect an accepted MTHI, MTLO or WBOTH in its own acceptance cycle, substituting only the written half or halves; MADD/MSUB are not forwarded.
REQ-042 Without HILO_BYPASS_EN, rdata SHALL be purely the registered value, with no combinational path from wdata.

Verification
REQ-050 Reset, HW=32: assert rst -> rdata=0, ready=1, done=0; release rst, WBOTH 0x1111_2222_3333_4444 -> rdata equals it the next cycle, done pulses once.
REQ-051 MTHI 0xAAAA_AAAA then MTLO 0x5555_5555 on consecutive cycles -> rdata=0xAAAA_AAAA_5555_5555; two done pulses; ready stays 1.
REQ-052 {HI,LO}=0x0000_0000_FFFF_FFFF, MADD 0x0000_0000_0000_0001 -> ready low 1 cycle; rdata=0x0000_0001_0000_0000 after edge 2; done in the next cycle.
REQ-053 {HI,LO}=0, MSUB 0x1 -> rdata=0xFFFF_FFFF_FFFF_FFFF (borrow propagates and wraps); req held during ACC_HI is accepted only after ready returns to 1.
REQ-054 rst pulsed in ACC_HI -> rdata=RST_VAL, no done pulse; with HILO_BYPASS_EN, an MTLO 0x1234 shows in rdata LO in the same cycle; without the macro, it appears one cycle later.

Source files
------------

// File: rtl/hilo_acc.sv
// hilo_acc: HI/LO register pair with plain writes and a two-cycle
// multiply-accumulate style add/subtract (LO on the first edge, HI plus
// carry/borrow on the second edge).
//
// Optional feature macro: HILO_BYPASS_EN
//   defined   -> rdata forwards an accepted MTHI/MTLO/WBOTH in its own cycle
//   undefined -> rdata is purely the registered {HI,LO}
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a request; plain writes complete in one edge
// ACC_HI | LO already updated; HI += / -= stored operand and carry
module hilo_acc #(
  parameter int              HW      = 32,
  parameter logic [2*HW-1:0] RST_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic [2:0]      op,
  input  logic [2*HW-1:0] wdata,
  output logic            ready,
  output logic            done,
  output logic [2*HW-1:0] rdata
);

  localparam logic [2:0] OP_MTHI  = 3'd1;
  localparam logic [2:0] OP_MTLO  = 3'd2;
  localparam logic [2:0] OP_WBOTH = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;

  typedef enum logic {
    IDLE   = 1'b0,
    ACC_HI = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nx;

  logic [HW-1:0]   hi;
  logic [HW-1:0]   lo;
  logic [HW-1:0]   op_hi;
  logic            cy;
  logic            is_sub;
  logic            done_q;

  logic [HW-1:0]   w_hi;
  logic [HW-1:0]   w_lo;
  logic            is_plain;
  logic            is_acc;
  logic            accept;
  logic [HW:0]     lo_ext;
  logic [HW-1:0]   cy_ext;
  logic [HW-1:0]   hi_nx;

  assign w_hi = wdata[2*HW-1:HW];
  assign w_lo = wdata[HW-1:0];

  // Opcode decode; codes 0, 6 and 7 fall through as no-ops.
  always_comb begin
    is_plain = 1'b0;
    is_acc   = 1'b0;
    case (op)
      OP_MTHI, OP_MTLO, OP_WBOTH: is_plain = 1'b1;
      OP_MADD, OP_MSUB:           is_acc   = 1'b1;
      default: ;
    endcase
  end

  assign ready  = (state == IDLE);
  assign accept = req && ready && (is_plain || is_acc);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: an accumulate always spends exactly one cycle in ACC_HI.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && is_acc) state_nx = ACC_HI;
      ACC_HI:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Low-half add/subtract; the extra top bit is the carry (add) or borrow (sub).
  always_comb begin
    lo_ext = {1'b0, lo} + {1'b0, w_lo};
    if (op == OP_MSUB) lo_ext = {1'b0, lo} - {1'b0, w_lo};
  end

  assign cy_ext = {{(HW-1){1'b0}}, cy};
  assign hi_nx  = is_sub ? (hi - op_hi - cy_ext) : (hi + op_hi + cy_ext);

  // HI/LO pair plus the operand/carry staged for the second accumulate edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi     <= RST_VAL[2*HW-1:HW];
      lo     <= RST_VAL[HW-1:0];
      op_hi  <= '0;
      cy     <= 1'b0;
      is_sub <= 1'b0;
    end else if (state == ACC_HI) begin
      hi <= hi_nx;
    end else if (accept) begin
      case (op)
        OP_MTHI:  hi <= w_hi;
        OP_MTLO:  lo <= w_lo;
        OP_WBOTH: begin
          hi <= w_hi;
          lo <= w_lo;
        end
        OP_MADD, OP_MSUB: begin
          lo     <= lo_ext[HW-1:0];
          cy     <= lo_ext[HW];
          op_hi  <= w_hi;
          is_sub <= (op == OP_MSUB);
        end
        default: ;
      endcase
    end
  end

  // Completion pulse: one cycle after a plain write or after the HI edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= (accept && is_plain) || (state == ACC_HI);
  end

  assign done = done_q;

`ifdef HILO_BYPASS_EN
  // Forward the written half (or halves) of an accepted plain write.
  always_comb begin
    rdata = {hi, lo};
    if (accept) begin
      case (op)
        OP_MTHI:  rdata[2*HW-1:HW] = w_hi;
        OP_MTLO:  rdata[HW-1:0]    = w_lo;
        OP_WBOTH: rdata            = wdata;
        default: ;
      endcase
    end
  end
`else
  // Registered value only; no path from wdata.
  assign rdata = {hi, lo};
`endif

endmodule

// File: tb/tb_hilo_acc.sv
// Self-checking bench for hilo_acc (HW=32): reset, a vector table,
// hand-written multi-cycle sequences and a randomized run against a
// 64-bit arithmetic reference model.
module tb_hilo_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [2:0]  op;
  logic [63:0] wdata;
  logic        ready;
  logic        done;
  logic [63:0] rdata;

  int pass_cnt = 0;
  int total_cnt = 0;

  hilo_acc #(.HW(32), .RST_VAL(64'h0)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .op    (op),
    .wdata (wdata),
    .ready (ready),
    .done  (done),
    .rdata (rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] w;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called at a negedge with ready=1; returns cycles until done and ready one cycle after acceptance.
  task automatic do_op(input logic [2:0] o, input logic [63:0] w, output int lat, output logic rdy1);
    req = 1'b1; op = o; wdata = w;
    @(negedge clk);
    req = 1'b0; op = 3'd0;
    rdy1 = ready;
    lat = 1;
    while (!done && lat < 6) begin
      @(negedge clk);
      lat++;
    end
  endtask

  function automatic logic [63:0] model(input logic [63:0] acc, input logic [2:0] o, input logic [63:0] w);
    logic [63:0] r;
    r = acc;
    case (o)
      3'd1: r[63:32] = w[63:32];
      3'd2: r[31:0]  = w[31:0];
      3'd3: r = w;
      3'd4: r = acc + w;
      3'd5: r = acc - w;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    int          lat;
    logic        rdy1;
    logic [63:0] acc;
    logic [63:0] w;
    logic [2:0]  o;

    tbl[0]  = '{3'd3, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, 1};
    tbl[1]  = '{3'd1, 64'hAAAA_AAAA_DEAD_BEEF, 64'hAAAA_AAAA_3333_4444, 1};
    tbl[2]  = '{3'd2, 64'hCAFE_F00D_5555_5555, 64'hAAAA_AAAA_5555_5555, 1};
    tbl[3]  = '{3'd3, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 1};
    tbl[4]  = '{3'd4, 64'h0000_0000_0000_0001, 64'h0000_0001_0000_0000, 2};
    tbl[5]  = '{3'd5, 64'h0000_0000_0000_0001, 64'h0000_0000_FFFF_FFFF, 2};
    tbl[6]  = '{3'd3, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1};
    tbl[7]  = '{3'd5, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 2};
    tbl[8]  = '{3'd4, 64'h0000_0001_0000_0001, 64'h0000_0001_0000_0000, 2};
    tbl[9]  = '{3'd5, 64'h8000_0000_8000_0000, 64'h8000_0000_8000_0000, 2};
    tbl[10] = '{3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_7FFF_FFFF, 2};

    rst = 1'b1; req = 1'b0; op = 3'd0; wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_rdata", rdata, 64'h0);
    chk("reset_ready", {63'h0, ready}, 64'h1);
    chk("reset_done",  {63'h0, done},  64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Vector table
    for (int i = 0; i < 11; i++) begin
      do_op(tbl[i].op, tbl[i].w, lat, rdy1);
      chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp);
      chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
      chk($sformatf("tbl%0d_ready1", i), {63'h0, rdy1}, (tbl[i].lat == 2) ? 64'h0 : 64'h1);
    end
    @(negedge clk);
    chk("done_single_pulse", {63'h0, done}, 64'h0);

    // Back-to-back MTHI then MTLO
    req = 1'b1; op = 3'd1; wdata = 64'hAAAA_AAAA_0000_0000;
    @(negedge clk);
    chk("b2b_ready", {63'h0, ready}, 64'h1);
    chk("b2b_done1", {63'h0, done}, 64'h1);
    op = 3'd2; wdata = 64'h0000_0000_5555_5555;
    @(negedge clk);
    req = 1'b0; op = 3'd0;
    chk("b2b_done2", {63'h0, done}, 64'h1);
    chk("b2b_rdata", rdata, 64'hAAAA_AAAA_5555_5555);
    @(negedge clk);
    chk("b2b_done_end", {63'h0, done}, 64'h0);

    // MSUB from zero with a request held through ACC_HI
    do_op(3'd3, 64'h0, lat, rdy1);
    req = 1'b1; op = 3'd5; wdata = 64'h1;
    @(negedge clk);
    op = 3'd2; wdata = 64'h0000_0000_0000_1234;
    chk("acchi_ready", {63'h0, ready}, 64'h0);
    chk("acchi_rdata", rdata, 64'h0000_0000_FFFF_FFFF);
    @(negedge clk);
    chk("msub_done", {63'h0, done}, 64'h1);
`ifdef HILO_BYPASS_EN
    chk("held_bypass_rdata", rdata, 64'hFFFF_FFFF_0000_1234);
`else
    chk("msub_rdata", rdata, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
    @(negedge clk);
    req = 1'b0; op = 3'd0;
    chk("held_done", {63'h0, done}, 64'h1);
    chk("held_rdata", rdata, 64'hFFFF_FFFF_0000_1234);

    // Reset in ACC_HI aborts without done
    req = 1'b1; op = 3'd4; wdata = 64'h0000_0005_0000_0001;
    @(negedge clk);
    req = 1'b0; op = 3'd0;
    chk("abort_in_acc", {63'h0, ready}, 64'h0);
    rst = 1'b1;
    #1;
    chk("abort_rdata", rdata, 64'h0);
    chk("abort_ready", {63'h0, ready}, 64'h1);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_done0", {63'h0, done}, 64'h0);
    @(negedge clk);
    chk("abort_done1", {63'h0, done}, 64'h0);
    chk("abort_rdata_after", rdata, 64'h0);

    // Same-cycle forwarding of MTLO
    req = 1'b1; op = 3'd2; wdata = 64'h0000_0000_0000_1234;
    #1;
`ifdef HILO_BYPASS_EN
    chk("bypass_same_cycle", rdata, 64'h0000_0000_0000_1234);
`else
    chk("nobypass_same_cycle", rdata, 64'h0);
`endif
    @(negedge clk);
    req = 1'b0; op = 3'd0;
    chk("mtlo_next_cycle", rdata, 64'h0000_0000_0000_1234);
    acc = 64'h0000_0000_0000_1234;

    // Randomized run against the arithmetic model
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3, 0) == 0) begin
        case ($urandom_range(2, 0))
          0: o = 3'd0;
          1: o = 3'd6;
          default: o = 3'd7;
        endcase
        req = 1'b1; op = o; wdata = {$urandom, $urandom};
        @(negedge clk);
        req = 1'b0; op = 3'd0;
        chk($sformatf("rnd%0d_nop_done", i), {63'h0, done}, 64'h0);
        chk($sformatf("rnd%0d_nop_rdata", i), rdata, acc);
      end
      o = 3'($urandom_range(5, 1));
      case ($urandom_range(3, 0))
        0: w = 64'hFFFF_FFFF_FFFF_FFFF;
        1: w = {32'($urandom_range(3, 0)), 32'hFFFF_FFFF};
        default: w = {$urandom, $urandom};
      endcase
      do_op(o, w, lat, rdy1);
      acc = model(acc, o, w);
      chk($sformatf("rnd%0d_rdata", i), rdata, acc);
      chk($sformatf("rnd%0d_lat", i), 64'(lat), (o >= 3'd4) ? 64'd2 : 64'd1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
